coef_table_mac: RTL



---
 rtl/coef_mac_pkg.sv | 15 +
 rtl/coef_table_regs.sv | 40 ++++
 rtl/coef_table_mac.sv | 96 +++++++++
 3 files changed

// File: rtl/coef_mac_pkg.sv
// coef_mac_pkg: shared widths, init pattern and default constants for coef_table_mac
package coef_mac_pkg;
  localparam int MULB_DEF = 3;
  localparam int TEMP_DEF = 21;
  localparam int MULZ_DEF = 11;
  localparam int ZVAL_DEF = 1;
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
  function automatic int init_val(input int r, input int c, input int cols, input int w);
    int v;
    v = r * cols + c;
    return (w >= 31) ? v : (v & ((1 << w) - 1));
  endfunction
endpackage

// File: rtl/coef_table_regs.sv
// coef_table_regs: coefficient register table with write port, reload and guarded combinational read
module coef_table_regs
  import coef_mac_pkg::*;
#(
  parameter int W    = 8,
  parameter int ROWS = 4,
  parameter int COLS = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [idx_w(ROWS)-1:0]   wr_row,
  input  logic [idx_w(COLS)-1:0]   wr_col,
  input  logic [W-1:0]             wr_data,
  input  logic                     reload,
  input  logic [idx_w(ROWS)-1:0]   rd_row,
  input  logic [idx_w(COLS)-1:0]   rd_col,
  output logic [W-1:0]             rd_data
);
  logic [W-1:0] tab [ROWS][COLS];
  logic         wr_ok;
  logic         rd_ok;
  assign wr_ok   = (int'(wr_row) < ROWS) && (int'(wr_col) < COLS);
  assign rd_ok   = (int'(rd_row) < ROWS) && (int'(rd_col) < COLS);
  assign rd_data = rd_ok ? tab[rd_row][rd_col] : '0;
  // Reset and reload restore the index pattern; reload beats a same-cycle write
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++)
          tab[r][c] <= W'(init_val(r, c, COLS, W));
    end else if (reload) begin
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++)
          tab[r][c] <= W'(init_val(r, c, COLS, W));
    end else if (wr_en && wr_ok) begin
      tab[wr_row][wr_col] <= wr_data;
    end
  end
endmodule

// File: rtl/coef_table_mac.sv
// coef_table_mac: pipelined XOUT = A - MULB*B - TEMP*tab[row][col] + MULZ*ZVAL modulo 2^W
module coef_table_mac
  import coef_mac_pkg::*;
#(
  parameter int W    = 8,
  parameter int ROWS = 4,
  parameter int COLS = 4,
  parameter int MULB = MULB_DEF,
  parameter int TEMP = TEMP_DEF,
  parameter int MULZ = MULZ_DEF,
  parameter int ZVAL = ZVAL_DEF
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     IN_VALID,
  output logic                     IN_READY,
  input  logic [W-1:0]             A,
  input  logic [W-1:0]             B,
  input  logic [idx_w(ROWS)-1:0]   ROW,
  input  logic [idx_w(COLS)-1:0]   COL,
  input  logic                     WR_EN,
  input  logic [idx_w(ROWS)-1:0]   WR_ROW,
  input  logic [idx_w(COLS)-1:0]   WR_COL,
  input  logic [W-1:0]             WR_DATA,
  input  logic                     RELOAD,
  output logic                     OUT_VALID,
  input  logic                     OUT_READY,
  output logic [W-1:0]             XOUT
);
  localparam logic [W-1:0] MB = W'(MULB);
  localparam logic [W-1:0] TC = W'(TEMP);
  localparam logic [W-1:0] MZ = W'(MULZ * ZVAL);
  logic         stall;
  logic         v1, v2, v3;
  logic [W-1:0] a1, b1, c1, p2, q2, d3, coef;
  assign stall    = OUT_VALID && !OUT_READY;
  assign IN_READY = !stall;
  coef_table_regs #(.W(W), .ROWS(ROWS), .COLS(COLS)) u_tab (
    .clk     (CLK),
    .rst     (RST),
    .wr_en   (WR_EN),
    .wr_row  (WR_ROW),
    .wr_col  (WR_COL),
    .wr_data (WR_DATA),
    .reload  (RELOAD),
    .rd_row  (ROW),
    .rd_col  (COL),
    .rd_data (coef)
  );
  // Accept stage: operands and the coefficient are frozen here, later table edits cannot touch them
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      v1 <= 1'b0;
      a1 <= '0;
      b1 <= '0;
      c1 <= '0;
    end else if (!stall) begin
      v1 <= IN_VALID;
      a1 <= A;
      b1 <= B;
      c1 <= coef;
    end
  end
  // Product stage: both products wrap to W bits
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      v2 <= 1'b0;
      p2 <= '0;
      q2 <= '0;
    end else if (!stall) begin
      v2 <= v1;
      p2 <= a1 - MB * b1;
      q2 <= TC * c1;
    end
  end
  // Difference stage: split from the final add so a result appears three edges after accept
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      v3 <= 1'b0;
      d3 <= '0;
    end else if (!stall) begin
      v3 <= v2;
      d3 <= p2 - q2;
    end
  end
  // Output register: XOUT only changes when a real result lands, so it stays put across bubbles and stalls
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      OUT_VALID <= 1'b0;
      XOUT      <= '0;
    end else if (!stall) begin
      OUT_VALID <= v3;
      XOUT      <= v3 ? d3 + MZ : XOUT;
    end
  end
endmodule
